// File: rtl/jk_count_driver_if.sv
// Bundle of control inputs and bank-drive outputs for the JK counter controller.
interface jk_count_driver_if #(
    parameter int unsigned WIDTH = 4
);
    logic             EN;
    logic             UP;
    logic             LOAD;
    logic [WIDTH-1:0] D;
    logic [WIDTH-1:0] Q;
    logic [WIDTH-1:0] J;
    logic [WIDTH-1:0] K;
    logic [WIDTH-1:0] PR;
    logic [WIDTH-1:0] CLR;
    logic             TC;

    // Controller side: consumes controls, drives the flip-flop bank.
    modport slave (
        input  EN, UP, LOAD, D,
        output Q, J, K, PR, CLR, TC
    );

    // Stimulus side: drives controls, observes the bank drive.
    modport master (
        output EN, UP, LOAD, D,
        input  Q, J, K, PR, CLR, TC
    );
endinterface

// File: rtl/jk_count_driver.sv
// Mod-MOD up/down counter controller producing JK excitation and PR/CLR forces
// for an external bank of WIDTH JK flip-flops, tracking the bank in Q.
module jk_count_driver #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned MOD   = 10
) (
    input  logic              CK,
    input  logic              RST,
    jk_count_driver_if.slave  bus
);

    typedef enum logic [1:0] {
        MODE_RESET,
        MODE_LOAD,
        MODE_COUNT,
        MODE_HOLD
    } mode_t;

    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MOD - 1);
    localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MOD);

    mode_t            mode;
    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] next_val;
    logic [WIDTH-1:0] j_val;
    logic [WIDTH-1:0] k_val;
    logic [WIDTH-1:0] pr_val;
    logic [WIDTH-1:0] clr_val;
    logic             tc_val;
    logic             at_or_above_max;
    logic             out_of_range;
    logic             at_zero;

    // Control priority: reset, then load, then count, else hold.
    always_comb begin
        mode = MODE_HOLD;
        if (RST) begin
            mode = MODE_RESET;
        end else if (bus.LOAD) begin
            mode = MODE_LOAD;
        end else if (bus.EN) begin
            mode = MODE_COUNT;
        end
    end

    // Next count value with explicit wrap, independent of natural overflow.
    always_comb begin
        at_or_above_max = (q_reg >= MAX_VAL);
        out_of_range    = ({1'b0, q_reg} >= MOD_EXT);
        at_zero         = (q_reg == '0);
        next_val        = q_reg;
        if (bus.UP) begin
            next_val = at_or_above_max ? '0 : q_reg + 1'b1;
        end else begin
            next_val = (at_zero || out_of_range) ? MAX_VAL : q_reg - 1'b1;
        end
    end

    // Bank drive: forces for reset/load, minimal JK excitation for counting.
    always_comb begin
        j_val   = '0;
        k_val   = '0;
        pr_val  = '1;
        clr_val = '1;
        tc_val  = 1'b0;
        unique case (mode)
            MODE_RESET: begin
                clr_val = '0;
            end
            MODE_LOAD: begin
                pr_val  = ~bus.D;
                clr_val = bus.D;
            end
            MODE_COUNT: begin
                // Set where 0->1, reset where 1->0; toggle code never used.
                j_val  = ~q_reg & next_val;
                k_val  = q_reg & ~next_val;
                tc_val = bus.UP ? (q_reg == MAX_VAL) : at_zero;
            end
            default: begin
            end
        endcase
    end

    // State mirror advances on the same edge as the flip-flop bank.
    always_ff @(posedge CK) begin
        if (RST) begin
            q_reg <= '0;
        end else if (bus.LOAD) begin
            q_reg <= bus.D;
        end else if (bus.EN) begin
            q_reg <= next_val;
        end
    end

    assign bus.Q   = q_reg;
    assign bus.J   = j_val;
    assign bus.K   = k_val;
    assign bus.PR  = pr_val;
    assign bus.CLR = clr_val;
    assign bus.TC  = tc_val;

endmodule

// File: doc/jk_count_driver.md
# jk_count_driver

Synchronous mod-N up/down counter controller that drives a bank of WIDTH JK flip-flops, one per counter bit. Each cycle it computes the J/K excitation and the PR/CLR force controls for that bank. It keeps an internal mirror of the bank state, so the bank and the controller advance in lockstep on the same CK edge. It sits directly upstream of the JK flip-flop stage. The flip-flop stage samples J, K, PR and CLR on posedge CK. It treats PR=1/CLR=0 as force-0, PR=0/CLR=1 as force-1, and PR=1/CLR=1 as normal JK operation.

## Interface
- WIDTH, 4, counter/bank width in bits
- MOD, 10, count modulus; 2 ≤ MOD ≤ 2^WIDTH
- CK  in  1  clock; all state changes on posedge
- RST  in  1  synchronous reset, active-high
- EN  in  1  count enable
- UP  in  1  direction: 1 = up, 0 = down
- LOAD  in  1  parallel load request
- D  in  WIDTH  load value
- Q  out  WIDTH  mirror of bank state (registered)
- J  out  WIDTH  per-bit J to flip-flop bank
- K  out  WIDTH  per-bit K to flip-flop bank
- PR  out  WIDTH  per-bit preset control to bank (0 with CLR=1 forces 1)
- CLR  out  WIDTH  per-bit clear control to bank (0 with PR=1 forces 0)
- TC  out  1  terminal count, combinational

## Operation
- Control priority: RST > LOAD > EN > hold.
- RST=1:
  - PR = all 1, CLR = all 0, J = K = 0, TC = 0.
  - Next edge: Q ← 0, and the bank clears.
- LOAD=1 (RST=0):
  - For each bit i: D[i]=1 → PR[i]=0, CLR[i]=1; D[i]=0 → PR[i]=1, CLR[i]=0.
  - J = K = 0.
  - Next edge: Q ← D, loaded as-is even if D ≥ MOD.
- EN=1, LOAD=0, RST=0:
  - PR = CLR = all 1.
  - Next value N:
    - UP=1: N = 0 if Q ≥ MOD-1, else Q+1.
    - UP=0: N = MOD-1 if Q = 0 or Q ≥ MOD, else Q-1.
  - Per-bit excitation, don't-cares resolved to 0:
    - Q[i]=0, N[i]=0 → J=0, K=0.
    - Q[i]=0, N[i]=1 → J=1, K=0.
    - Q[i]=1, N[i]=0 → J=0, K=1.
    - Q[i]=1, N[i]=1 → J=0, K=0.
  - The J=K=1 toggle code is never emitted.
  - Next edge: Q ← N.
- Hold (EN=0, LOAD=0, RST=0): PR = CLR = all 1, J = K = 0, Q unchanged.
- TC = EN & ~LOAD & ~RST & ((UP & Q = MOD-1) | (~UP & Q = 0)).
- PR=0/CLR=0 together is never emitted on any bit.
- Arithmetic is modulo 2^WIDTH internally. Wrap handling is explicit as above, never by natural overflow (matters when MOD < 2^WIDTH).

## Timing
- Q is the only registered output. J, K, PR, CLR and TC are combinational from Q and the controls.
- Controls are sampled at edge n. The bank and Q both take the new value at edge n; latency from control to Q is one edge.
- Invariant after the first reset edge: bank state equals Q at every edge.
- RST asserted mid-count: Q = 0 at the very next edge, regardless of LOAD/EN.
- LOAD and EN both high: load wins; no count occurs that cycle.
- Direction change (UP toggled) takes effect on the same cycle's excitation.
- Before the first RST, Q is unknown. The bench applies RST for at least 1 cycle at start.

## Test plan
- Reset → 3 edges of RST=1 then EN=1, UP=1 → Q = 0 after reset, PR=F, CLR=0 during RST; then Q = 1, 2, 3 on successive edges.
- Up wrap (MOD=10) → LOAD D=8, then EN=1, UP=1 → Q = 8, 9, 0, 1. TC=1 only in the cycle Q=9. At Q=9: J=0000, K=1001.
- Down wrap → LOAD D=1, EN=1, UP=0 → Q = 1, 0, 9, 8. TC=1 only in the cycle Q=0. At Q=0: J=1001, K=0000.
- Load vs enable → LOAD=1, EN=1, D=6 → PR=1001, CLR=0110, J=K=0, TC=0; Q=6 next edge, no count. Out-of-range load D=13, then up → Q = 13, 0. Then down from 13 → Q = 13, 9.
- Hold and mid-count reset → EN=0 for 4 cycles at Q=5 → Q stays 5, J=K=0, PR=CLR=F. Then RST with EN=1, LOAD=1 → Q = 0 next edge.
- Lockstep check → random EN/UP/LOAD/D for 1000 cycles with a JK flip-flop bank model attached → bank state equals Q every edge, and no bit ever sees PR=CLR=0 or J=K=1.
